// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: shared constants for the seven-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Entry n holds the pattern for hex digit n (entry 15 written first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display-side bundle of the scan driver.
// master = the block feeding value/controls, slave = the scan driver.
interface seg7_scan_if;
  logic        dived_clk;
  logic        enable;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output dived_clk, enable, value, dp_mask,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  dived_clk, enable, value, dp_mask,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 4-bit hex to active-low 7-segment decoder.
module seg7_decode
  import seg7_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed seven-segment driver stepped by rising edges of the
// (synchronised) dived_clk level. The value is snapshotted at each frame wrap
// so a frame never mixes old and new digits.
// Optional macro SEG7_LZB_EN: leading-zero blanking of digits above digit 0.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VAL_W = 4 * DIGITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_d_reg;
  logic                   step;

  logic [IDX_W-1:0]       idx_reg;
  logic [VAL_W-1:0]       shadow_val_reg;
  logic [DIGITS-1:0]      shadow_dp_reg;
  logic                   frame_done_reg;
  logic                   running_reg;

  logic [7:0]             an_reg;
  logic [6:0]             seg_reg;
  logic                   dp_reg;

  logic [3:0]             nibble;
  logic [6:0]             seg_dec;
  logic                   blank;
  logic                   show;
  logic [7:0]             an_next;

  // Synchroniser chain plus one extra flop to detect the rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg   <= '0;
      sync_d_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], bus.dived_clk};
      sync_d_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign step = sync_reg[SYNC_STAGES-1] & ~sync_d_reg;

  // Digit index; snapshot of value/dp_mask and frame pulse on wrap.
  // running_reg keeps the display dark until the first step after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg        <= IDX_LAST;
      shadow_val_reg <= '0;
      shadow_dp_reg  <= '0;
      frame_done_reg <= 1'b0;
      running_reg    <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (step) begin
        running_reg <= 1'b1;
        if (idx_reg == IDX_LAST) begin
          idx_reg        <= '0;
          shadow_val_reg <= bus.value[VAL_W-1:0];
          shadow_dp_reg  <= bus.dp_mask[DIGITS-1:0];
          frame_done_reg <= 1'b1;
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end
    end
  end

  assign nibble = shadow_val_reg[{idx_reg, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (seg_dec)
  );

`ifdef SEG7_LZB_EN
  // upper_zero[i]: shadow nibbles i..DIGITS-1 are all zero.
  logic [DIGITS-1:0] upper_zero;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_upper_zero
    assign upper_zero[gi] = (shadow_val_reg[VAL_W-1:4*gi] == '0);
  end
  assign blank = (idx_reg != '0) && upper_zero[idx_reg];
`else
  assign blank = 1'b0;
`endif

  assign show = bus.enable & ~blank;

  // One anode per digit; positions beyond DIGITS stay off.
  for (genvar gi = 0; gi < 8; gi++) begin : g_anode
    if (gi < DIGITS) begin : g_used
      assign an_next[gi] = ~(show && (idx_reg == IDX_W'(gi)));
    end else begin : g_unused
      assign an_next[gi] = 1'b1;
    end
  end

  // Output register, loaded every cycle once scanning has started.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_reg  <= AN_OFF;
      seg_reg <= SEG_BLANK;
      dp_reg  <= 1'b1;
    end else if (running_reg) begin
      an_reg  <= an_next;
      seg_reg <= blank ? SEG_BLANK : seg_dec;
      dp_reg  <= show ? ~shadow_dp_reg[idx_reg] : 1'b1;
    end
  end

  assign bus.an         = an_reg;
  assign bus.seg        = seg_reg;
  assign bus.dp         = dp_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed bench for seg7_scan (DIGITS=8, SYNC_STAGES=2).
// A history-based model predicts every output on every cycle; literal
// expectations at key points pin the model.
module tb_seg7_scan;

  localparam int DIG  = 8;
  localparam int SYNC = 2;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fd_count = 0;
  int   rise_n = 0;

  logic        lvl_h  [MAXC];
  logic        rst_h  [MAXC];
  logic        en_h   [MAXC];
  logic [31:0] val_h  [MAXC];
  logic [7:0]  dpm_h  [MAXC];

  seg7_scan_if bus ();

  seg7_scan #(.DIGITS(DIG), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Expected outputs after clock edge k. A dived_clk rise first seen at edge
  // j moves the digit at edge j+SYNC, and the display follows one edge later.
  task automatic model(input int k, output logic [7:0] e_an, output logic [6:0] e_seg,
                       output logic e_dp, output logic e_fd, output logic seg_valid);
    int rs, cnt, frame_u, d;
    logic prev, blank;
    logic [31:0] sh;
    logic [7:0]  dm;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; seg_valid = 1'b1;
    if (rst_h[k]) return;
    rs = 0;
    for (int i = k; i >= 1; i--) begin
      if (rst_h[i]) begin rs = i; break; end
    end
    cnt = 0; frame_u = 0;
    for (int j = rs + 1; j + SYNC <= k; j++) begin
      prev = (j - 1 <= rs) ? 1'b0 : lvl_h[j-1];
      if (lvl_h[j] && !prev) begin
        if (j + SYNC == k && (cnt % DIG) == 0) e_fd = 1'b1;
        if (j + SYNC <= k - 1) begin
          if ((cnt % DIG) == 0) frame_u = j + SYNC;
          cnt++;
        end
      end
    end
    if (cnt == 0) return;
    d  = (cnt - 1) % DIG;
    sh = val_h[frame_u];
    dm = dpm_h[frame_u];
    blank = 1'b0;
`ifdef SEG7_LZB_EN
    if (d > 0 && (sh >> (4 * d)) == 32'h0) blank = 1'b1;
`endif
    e_seg = blank ? 7'h7F : seg_of(4'(sh >> (4 * d)));
    if (en_h[k] && !blank) begin
      e_an = ~(8'h01 << d);
      e_dp = ~dm[d];
    end
    seg_valid = en_h[k] || blank;
  endtask

  // Record the inputs the DUT sees at each rising edge.
  initial begin
    rst_h[0] = 1'b1;
    lvl_h[0] = 1'b0;
    forever begin
      @(posedge clk);
      if (cyc < MAXC - 1) cyc++;
      rst_h[cyc] = ~rst;
      lvl_h[cyc] = bus.dived_clk;
      en_h[cyc]  = bus.enable;
      val_h[cyc] = bus.value;
      dpm_h[cyc] = bus.dp_mask;
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  initial begin
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd, seg_valid;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        model(cyc, e_an, e_seg, e_dp, e_fd, seg_valid);
        chk("an", 32'(bus.an), 32'(e_an));
        if (seg_valid) chk("seg", 32'(bus.seg), 32'(e_seg));
        chk("dp", 32'(bus.dp), 32'(e_dp));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
        if (bus.frame_done === 1'b1) fd_count++;
      end
    end
  end

  task automatic rise();
    @(negedge clk);
    bus.dived_clk = 1'b1;
    repeat (5) @(negedge clk);
    bus.dived_clk = 1'b0;
    repeat (5) @(negedge clk);
    rise_n++;
    $display("rise %0d: an=%h seg=%h dp=%b frames=%0d", rise_n, bus.an, bus.seg, bus.dp, fd_count);
  endtask

  initial begin
    rst = 1'b0;
    bus.dived_clk = 1'b0;
    bus.enable    = 1'b1;
    bus.value     = 32'h01234567;
    bus.dp_mask   = 8'hA5;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_an", 32'(bus.an), 32'hFF);
    chk("idle_seg", 32'(bus.seg), 32'h7F);
    chk("idle_dp", 32'(bus.dp), 32'h1);
    chk("idle_fd_count", fd_count, 0);

    rise();
    chk("r1_an", 32'(bus.an), 32'hFE);
    chk("r1_seg", 32'(bus.seg), 32'h78);
    chk("r1_dp", 32'(bus.dp), 32'h0);
    chk("r1_frames", fd_count, 1);
    rise();
    chk("r2_an", 32'(bus.an), 32'hFD);
    chk("r2_seg", 32'(bus.seg), 32'h02);
    rise();
    bus.value = 32'hFFFFFFFF;
    rise();
    chk("r4_seg_old", 32'(bus.seg), 32'h19);
    repeat (4) rise();
    chk("r8_an", 32'(bus.an), 32'h7F);
    chk("r8_seg", 32'(bus.seg), 32'h40);
    rise();
    chk("r9_an", 32'(bus.an), 32'hFE);
    chk("r9_seg", 32'(bus.seg), 32'h0E);
    repeat (7) rise();
    chk("r16_frames", fd_count, 2);

    // Long high level then fall: one step only.
    @(negedge clk);
    bus.dived_clk = 1'b1;
    repeat (30) @(negedge clk);
    chk("hold_an", 32'(bus.an), 32'hFE);
    bus.dived_clk = 1'b0;
    repeat (15) @(negedge clk);
    chk("fall_an", 32'(bus.an), 32'hFE);
    chk("r17_frames", fd_count, 3);
    rise_n++;

    rise();
    chk("r18_an", 32'(bus.an), 32'hFD);
    @(negedge clk);
    bus.enable  = 1'b0;
    bus.value   = 32'h89ABCDEF;
    bus.dp_mask = 8'h02;
    repeat (SYNC + 2) @(negedge clk);
    chk("dis_an", 32'(bus.an), 32'hFF);
    chk("dis_dp", 32'(bus.dp), 32'h1);
    repeat (7) rise();
    chk("dis_frames", fd_count, 4);
    chk("dis_an_after", 32'(bus.an), 32'hFF);
    bus.enable = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    chk("en_an", 32'(bus.an), 32'hFE);
    chk("en_seg", 32'(bus.seg), 32'h0E);
    rise();
    chk("r26_an", 32'(bus.an), 32'hFD);
    chk("r26_seg", 32'(bus.seg), 32'h06);
    chk("r26_dp", 32'(bus.dp), 32'h0);

    // Asynchronous reset mid-frame.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_an", 32'(bus.an), 32'hFF);
    chk("arst_seg", 32'(bus.seg), 32'h7F);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_an", 32'(bus.an), 32'hFF);
    rise();
    chk("post_rst_r1_an", 32'(bus.an), 32'hFE);
    chk("post_rst_r1_seg", 32'(bus.seg), 32'h0E);

`ifdef SEG7_LZB_EN
    bus.value = 32'h00000A30;
    repeat (8) rise();
    chk("lzb_d0_seg", 32'(bus.seg), 32'h40);
    rise();
    chk("lzb_d1_seg", 32'(bus.seg), 32'h30);
    rise();
    chk("lzb_d2_seg", 32'(bus.seg), 32'h08);
    rise();
    chk("lzb_d3_an", 32'(bus.an), 32'hFF);
    bus.value = 32'h0;
    repeat (5) rise();
    chk("lzb0_d0_an", 32'(bus.an), 32'hFE);
    chk("lzb0_d0_seg", 32'(bus.seg), 32'h40);
    rise();
    chk("lzb0_d1_an", 32'(bus.an), 32'hFF);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Multiplexed seven-segment display driver for board bring-up of the CPU.
- Sits directly downstream of the clock divider and consumes its slow toggling output (`dived_clk`) as a scan-rate reference.
- `dived_clk` is used as a sampled data signal, never as a clock.
- Each rising edge of `dived_clk` advances the scan by one digit. A frame-coherent snapshot of a 32-bit debug value (e.g. PC) is shown on eight common-anode digits.

Parameters:
- DIGITS, 8, number of digits scanned (legal 1..8); value width used = 4*DIGITS.
- SYNC_STAGES, 2, synchroniser depth for `dived_clk` (legal 2..3).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- dived_clk  in  1  slow toggling signal from the clock divider; asynchronous to nothing but treated as async.
- enable  in  1  1 = display on; 0 = all anodes off.
- value  in  32  hex value; digit i shows value[4i+3:4i].
- dp_mask  in  8  bit i = 1 lights the decimal point of digit i.
- an  out  8  anode selects, active-low, one-hot-low while scanning.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-clk pulse at start of each frame.

Behaviour:

Reset (rst = 0, asynchronous):
- an = 8'hFF, seg = 7'h7F, dp = 1, frame_done = 0.
- Digit index idx = DIGITS-1; shadow value/dp regs = 0; sync chain and edge register = 0.
- Reset mid-frame blanks the display immediately. After release, behaviour is identical to power-up.

Synchronisation and stepping:
- `dived_clk` passes through SYNC_STAGES flops.
- step = sync_out & ~sync_out_d, i.e. a rising edge only; falling edges are ignored.
- `dived_clk` must hold each level for at least SYNC_STAGES+1 clk cycles; shorter pulses may be lost.

Index update (on a clk edge with step = 1):
- If idx == DIGITS-1: idx wraps to 0, value/dp_mask are latched into the shadow regs, and frame_done = 1 for exactly that one following cycle.
- Otherwise idx = idx + 1. The index counter is $clog2(DIGITS) bits wide, minimum 1.

Outputs:
- Registered, from the new idx and the shadow regs; valid one clk after the idx update.
- Latency from a `dived_clk` rise to `an` changing: SYNC_STAGES+2 clk cycles.
- Changes to value/dp_mask mid-frame have no effect until the next wrap, so digits are never torn.

enable:
- enable = 0: scanning and shadow latching continue, but an = 8'hFF and dp = 1.
- enable is sampled in the same cycle as the output register load.

Unused anodes:
- an bits at positions >= DIGITS are always 1.

Hex decode (active-low, {g..a}):
- 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78
- 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined: digit i > 0 is blanked (its anode held high, dp = 1) when shadow nibbles i..DIGITS-1 are all zero. Digit 0 is always shown.
- Not defined: all digits are always shown, including leading zeros.

Decomposition:
- Shared package holds:
  - the 16-entry segment constant table;
  - SEG_BLANK = 7'h7F;
  - AN_OFF = 8'hFF.
- Natural sub-module: seg7_decode, a purely combinational 4-bit to 7-bit active-low decoder, instantiated once.

Test Plan:
- Reset released, no `dived_clk` edge -> an = FF, seg = 7F, dp = 1, frame_done = 0 held indefinitely.
- value = 32'h01234567, enable = 1, first `dived_clk` rise -> frame_done one pulse; an = FE, seg = 78. Second rise -> an = FD, seg = 02. Eighth rise -> an = 7F, seg = 40.
- value changed to 32'hFFFFFFFF after the 3rd rise -> digits 3..7 still show the old nibbles; after the 9th rise (frame 2) -> seg = 0E on every digit.
- 16 `dived_clk` rises -> exactly 2 frame_done pulses, each 1 clk wide. Falling edges and levels held high -> no index change.
- enable = 0 mid-frame -> an = FF and dp = 1 within SYNC_STAGES+2 cycles, while frame_done still pulses. enable = 1 again -> scanning resumes at the correct digit. Also assert rst low mid-frame -> an = FF immediately (asynchronously).
- SEG7_LZB_EN defined, value = 32'h00000A30 -> digits 3..7 never see an active anode. Digits 0..2 show 40, 30, 08. Value 0 -> only digit 0 is lit (40).
